// File: rtl/node_port_io_pkg.sv
// -----------------------------------------------------------------------------
// node_port_io_pkg
// Shared definitions for the TIS-100 node port-transfer unit:
//   - target codes as produced by the instruction decoder
//   - bit positions of each neighbour inside the 4-bit handshake vectors
//   - controller state encoding
//   - arbitration orders for ANY reads and ANY writes
//   - small helpers converting between target codes and port masks
// -----------------------------------------------------------------------------
package node_port_io_pkg;

  localparam int DEFAULT_WIDTH = 11;

  localparam logic [2:0] TARGET_NIL   = 3'd0;
  localparam logic [2:0] TARGET_ACC   = 3'd1;
  localparam logic [2:0] TARGET_UP    = 3'd2;
  localparam logic [2:0] TARGET_DOWN  = 3'd3;
  localparam logic [2:0] TARGET_LEFT  = 3'd4;
  localparam logic [2:0] TARGET_RIGHT = 3'd5;
  localparam logic [2:0] TARGET_ANY   = 3'd6;
  localparam logic [2:0] TARGET_LAST  = 3'd7;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  typedef enum logic [1:0] {
    PIO_IDLE = 2'd0,
    PIO_RD   = 2'd1,
    PIO_WR   = 2'd2,
    PIO_DONE = 2'd3
  } pioState_e;

  // Priority orders packed as four 2-bit port indices; bits [1:0] hold the
  // highest-priority port. Reads prefer LEFT, RIGHT, UP, DOWN; writes prefer
  // UP, LEFT, RIGHT, DOWN.
  localparam logic [7:0] READ_ORDER  = {2'd1, 2'd0, 2'd3, 2'd2};
  localparam logic [7:0] WRITE_ORDER = {2'd1, 2'd3, 2'd2, 2'd0};

  // Fixed directional target to one-hot port mask; anything else maps to none.
  function automatic logic [3:0] targetToMask(input logic [2:0] target);
    logic [3:0] mask;
    mask = 4'b0000;
    if (target >= TARGET_UP && target <= TARGET_RIGHT) begin
      mask = 4'b0001 << (target - TARGET_UP);
    end
    return mask;
  endfunction

  // One-hot port vector back to its directional target code (NIL if empty).
  function automatic logic [2:0] maskToTarget(input logic [3:0] mask);
    logic [2:0] target;
    target = TARGET_NIL;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        target = 3'(i) + TARGET_UP;
      end
    end
    return target;
  endfunction

endpackage

// File: rtl/node_port_io_port_arbiter.sv
// -----------------------------------------------------------------------------
// port_arbiter
// Decodes a read or write target into the set of ports that should see this
// node's half of the handshake.
//   sel_i      target code (UP..RIGHT, ANY, LAST)
//   lastDir_i  current LAST direction as a target code
//   partner_i  the neighbours' half of the handshake (in_valid or out_ready)
//   mask_o     ports on which to assert in_ready / out_valid
//   lastNil_o  LAST selected while no LAST direction exists yet: the transfer
//              completes without any handshake
// ORDER selects the ANY priority (see node_port_io_pkg).
// -----------------------------------------------------------------------------
module port_arbiter
  import node_port_io_pkg::*;
#(
  parameter logic [7:0] ORDER = READ_ORDER
) (
  input  logic [2:0] sel_i,
  input  logic [2:0] lastDir_i,
  input  logic [3:0] partner_i,
  output logic [3:0] mask_o,
  output logic       lastNil_o
);

  logic [3:0] pick;

  // Fixed-priority one-hot pick among active partners. Walking from lowest to
  // highest priority lets the highest-priority hit overwrite the others.
  always_comb begin
    pick = 4'b0000;
    for (int i = 3; i >= 0; i--) begin
      if (partner_i[ORDER[2*i +: 2]]) begin
        pick = 4'b0001 << ORDER[2*i +: 2];
      end
    end
  end

  // ANY offers all four ports until some partner responds, then narrows to the
  // single winner so no second port ever sees both handshake halves.
  always_comb begin
    mask_o    = 4'b0000;
    lastNil_o = 1'b0;
    case (sel_i)
      TARGET_UP, TARGET_DOWN, TARGET_LEFT, TARGET_RIGHT: begin
        mask_o = targetToMask(sel_i);
      end
      TARGET_ANY: begin
        mask_o = (|partner_i) ? pick : 4'b1111;
      end
      TARGET_LAST: begin
        mask_o    = targetToMask(lastDir_i);
        lastNil_o = (lastDir_i == TARGET_NIL);
      end
      default: begin
        mask_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/node_port_io.sv
// -----------------------------------------------------------------------------
// node_port_io
// Blocking port-transfer unit of a TIS-100 execution node. Executes the
// directional source read and/or destination write of the current op using
// valid/ready handshakes to the four neighbours, stalling until done.
//   clk, rst_n              clock, asynchronous active-low reset
//   read_req/read_sel       directional source request and target code
//   write_req/write_sel     directional destination request and target code
//   write_data              word to send when there is no directional source
//   read_data               word captured by the last read (registered)
//   done                    one-cycle pulse when all transfers are finished
//   stall                   request pending and not yet done
//   in_valid/in_data/in_ready    inbound handshakes, {RIGHT,LEFT,DOWN,UP}
//   out_valid/out_data/out_ready outbound handshakes, shared data word
//   last_dir                current LAST target code
// -----------------------------------------------------------------------------
module node_port_io
  import node_port_io_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               read_req,
  input  logic [2:0]         read_sel,
  input  logic               write_req,
  input  logic [2:0]         write_sel,
  input  logic [WIDTH-1:0]   write_data,
  output logic [WIDTH-1:0]   read_data,
  output logic               done,
  output logic               stall,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic [3:0]         out_valid,
  output logic [WIDTH-1:0]   out_data,
  input  logic [3:0]         out_ready,
  output logic [2:0]         last_dir
);

  pioState_e        state_q, state_d;
  logic [WIDTH-1:0] readData_q, readData_d;
  logic [2:0]       lastDir_q, lastDir_d;

  logic [3:0]       rdMask, wrMask;
  logic             rdNil, wrNil;
  logic [3:0]       rdHit, wrHit;
  logic             rdXfer, wrXfer;
  logic [WIDTH-1:0] rdWord;

  port_arbiter #(.ORDER(READ_ORDER)) readArb (
    .sel_i     (read_sel),
    .lastDir_i (lastDir_q),
    .partner_i (in_valid),
    .mask_o    (rdMask),
    .lastNil_o (rdNil)
  );

  port_arbiter #(.ORDER(WRITE_ORDER)) writeArb (
    .sel_i     (write_sel),
    .lastDir_i (lastDir_q),
    .partner_i (out_ready),
    .mask_o    (wrMask),
    .lastNil_o (wrNil)
  );

  // The masks are at most one-hot once a partner responds, so a transfer is
  // simply any overlap of our mask with the partner's signal in the right state.
  assign rdHit  = (state_q == PIO_RD) ? (rdMask & in_valid) : 4'b0000;
  assign wrHit  = (state_q == PIO_WR) ? (wrMask & out_ready) : 4'b0000;
  assign rdXfer = |rdHit;
  assign wrXfer = |wrHit;

  // Select the inbound word of the port that completed the read.
  always_comb begin
    rdWord = '0;
    for (int p = 0; p < 4; p++) begin
      if (rdHit[p]) begin
        rdWord = in_data[p*WIDTH +: WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PIO_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: read first, then write, then a single DONE cycle. A LAST
  // transfer with no LAST direction yet completes without waiting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PIO_IDLE: begin
        if (read_req) begin
          state_d = PIO_RD;
        end else if (write_req) begin
          state_d = PIO_WR;
        end
      end
      PIO_RD: begin
        if (rdNil || rdXfer) begin
          state_d = write_req ? PIO_WR : PIO_DONE;
        end
      end
      PIO_WR: begin
        if (wrNil || wrXfer) begin
          state_d = PIO_DONE;
        end
      end
      PIO_DONE: begin
        state_d = PIO_IDLE;
      end
      default: begin
        state_d = PIO_IDLE;
      end
    endcase
  end

  // Outputs: handshake halves only in their own state; out_data is forced to
  // zero outside WR so the bus is quiet when nothing is offered.
  always_comb begin
    in_ready  = 4'b0000;
    out_valid = 4'b0000;
    out_data  = '0;
    done      = 1'b0;
    case (state_q)
      PIO_RD: begin
        in_ready = rdMask;
      end
      PIO_WR: begin
        out_valid = wrMask;
        out_data  = read_req ? readData_q : write_data;
      end
      PIO_DONE: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  assign stall = (read_req | write_req) & ~done;

  // Datapath next state: capture the read word (zero for a LAST read with no
  // LAST direction) and remember the port used by any ANY transfer.
  always_comb begin
    readData_d = readData_q;
    lastDir_d  = lastDir_q;
    if ((state_q == PIO_RD) && rdNil) begin
      readData_d = '0;
    end else if (rdXfer) begin
      readData_d = rdWord;
    end
    if (rdXfer && (read_sel == TARGET_ANY)) begin
      lastDir_d = maskToTarget(rdHit);
    end
    if (wrXfer && (write_sel == TARGET_ANY)) begin
      lastDir_d = maskToTarget(wrHit);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readData_q <= '0;
      lastDir_q  <= TARGET_NIL;
    end else begin
      readData_q <= readData_d;
      lastDir_q  <= lastDir_d;
    end
  end

  assign read_data = readData_q;
  assign last_dir  = lastDir_q;

endmodule

// File: tb/tb_node_port_io.sv
// -----------------------------------------------------------------------------
// tb_node_port_io
// Directed and random transfers against a behavioural model of the node's
// ports: each neighbour becomes valid/ready a chosen number of cycles into the
// phase, and the model decides which port wins, when, and with what word.
// -----------------------------------------------------------------------------
module tb_node_port_io;

  localparam int W     = 11;
  localparam int NEVER = 1000;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           read_req, write_req;
  logic [2:0]     read_sel, write_sel;
  logic [W-1:0]   write_data;
  logic [W-1:0]   read_data;
  logic           done, stall;
  logic [3:0]     in_valid, in_ready, out_valid, out_ready;
  logic [4*W-1:0] in_data;
  logic [W-1:0]   out_data;
  logic [2:0]     last_dir;

  int total = 0;
  int bad   = 0;

  // Current operation and neighbour behaviour (port index 0..3 = UP,DOWN,LEFT,RIGHT).
  logic         opRreq, opWreq;
  logic [2:0]   opRsel, opWsel;
  logic [W-1:0] opWdata;
  int           validDelay[4];
  logic [W-1:0] validData[4];
  int           readyDelay[4];

  // Model state: LAST direction (target code) and last word read.
  logic [2:0]   mLast;
  logic [W-1:0] mReadData;

  // ANY priorities, as port indices, highest first.
  int readPrio[4]  = '{2, 3, 0, 1};
  int writePrio[4] = '{0, 2, 3, 1};

  always #5 clk = ~clk;

  node_port_io #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .read_req   (read_req),
    .read_sel   (read_sel),
    .write_req  (write_req),
    .write_sel  (write_sel),
    .write_data (write_data),
    .read_data  (read_data),
    .done       (done),
    .stall      (stall),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .last_dir   (last_dir)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rq, input logic wq,
                               input logic [3:0] iv, input logic [3:0] ordy);
    read_req   = rq;
    read_sel   = opRsel;
    write_req  = wq;
    write_sel  = opWsel;
    write_data = opWdata;
    in_valid   = iv;
    out_ready  = ordy;
    in_data    = {validData[3], validData[2], validData[1], validData[0]};
  endtask

  task automatic setOp(input logic rq, input logic [2:0] rs, input logic wq,
                       input logic [2:0] ws, input logic [W-1:0] wd);
    opRreq = rq; opRsel = rs; opWreq = wq; opWsel = ws; opWdata = wd;
  endtask

  // Which port a transfer uses and how many waiting cycles precede it.
  // port = -1 means LAST with no LAST direction: no handshake at all.
  function automatic void resolvePort(input bit isRead, input logic [2:0] sel,
                                      output int port, output int t);
    int d[4];
    int pr[4];
    for (int i = 0; i < 4; i++) begin
      d[i]  = isRead ? validDelay[i] : readyDelay[i];
      pr[i] = isRead ? readPrio[i] : writePrio[i];
    end
    port = -1;
    t    = 0;
    if (sel == 3'd7 && mLast == 3'd0) return;
    if (sel == 3'd6) begin
      t = NEVER;
      for (int i = 0; i < 4; i++) if (d[i] < t) t = d[i];
      for (int i = 3; i >= 0; i--) if (d[pr[i]] <= t) port = pr[i];
    end else begin
      port = (sel == 3'd7) ? int'(mLast) - 2 : int'(sel) - 2;
      t    = d[port];
    end
  endfunction

  // ANY mask seen by the neighbours at a given cycle of the phase.
  function automatic logic [3:0] anyPick(input bit isRead, input int idx);
    int p;
    int d;
    for (int i = 0; i < 4; i++) begin
      p = isRead ? readPrio[i] : writePrio[i];
      d = isRead ? validDelay[p] : readyDelay[p];
      if (d <= idx) return 4'b0001 << p;
    end
    return 4'b1111;
  endfunction

  task automatic runOp(input string name);
    int rPort, rT, wPort, wT, rdLen, wrLen, wrStart, doneCyc;
    logic [W-1:0] expRead, expOut;
    logic [3:0] iv, ordy, expIn, expOutV;
    bit inRd, inWr;
    rPort = -1; rT = 0; wPort = -1; wT = 0; rdLen = 0; wrLen = 0;
    expRead = mReadData;
    if (opRreq) begin
      resolvePort(1'b1, opRsel, rPort, rT);
      rdLen   = rT + 1;
      expRead = (rPort < 0) ? '0 : validData[rPort];
      if (opRsel == 3'd6) mLast = 3'(rPort + 2);
    end
    expOut = opRreq ? expRead : opWdata;
    if (opWreq) begin
      resolvePort(1'b0, opWsel, wPort, wT);
      wrLen = wT + 1;
      if (opWsel == 3'd6) mLast = 3'(wPort + 2);
    end
    wrStart = 1 + rdLen;
    doneCyc = wrStart + wrLen;
    for (int cyc = 0; cyc <= doneCyc; cyc++) begin
      @(posedge clk); #1;
      inRd = opRreq && cyc >= 1 && cyc < 1 + rdLen;
      inWr = opWreq && cyc >= wrStart && cyc < wrStart + wrLen;
      iv = 4'b0000; ordy = 4'b0000; expIn = 4'b0000; expOutV = 4'b0000;
      for (int p = 0; p < 4; p++) begin
        if (inRd && (cyc - 1) >= validDelay[p]) iv[p] = 1'b1;
        if (inWr && (cyc - wrStart) >= readyDelay[p]) ordy[p] = 1'b1;
      end
      if (inRd && rPort >= 0)
        expIn = (opRsel == 3'd6) ? anyPick(1'b1, cyc - 1) : (4'b0001 << rPort);
      if (inWr && wPort >= 0)
        expOutV = (opWsel == 3'd6) ? anyPick(1'b0, cyc - wrStart) : (4'b0001 << wPort);
      applyStimulus(opRreq, opWreq, iv, ordy);
      #1;
      checkOutput($sformatf("%s@%0d in_ready", name, cyc), in_ready, expIn);
      checkOutput($sformatf("%s@%0d out_valid", name, cyc), out_valid, expOutV);
      if (inWr) checkOutput($sformatf("%s@%0d out_data", name, cyc), out_data, expOut);
      checkOutput($sformatf("%s@%0d done", name, cyc), done, cyc == doneCyc);
      checkOutput($sformatf("%s@%0d stall", name, cyc), stall, cyc != doneCyc);
    end
    checkOutput({name, " read_data"}, read_data, expRead);
    checkOutput({name, " last_dir"}, last_dir, mLast);
    mReadData = expRead;
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
    #1;
    checkOutput({name, " idle done"}, done, 1'b0);
    checkOutput({name, " idle handshakes"}, {in_ready, out_valid}, 8'h00);
  endtask

  task automatic setDelays(input int v0, input int v1, input int v2, input int v3,
                           input int r0, input int r1, input int r2, input int r3);
    validDelay = '{v0, v1, v2, v3};
    readyDelay = '{r0, r1, r2, r3};
    for (int p = 0; p < 4; p++) validData[p] = W'($urandom);
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    mLast = 3'd0;
    mReadData = '0;
    setOp(1'b0, 3'd2, 1'b0, 3'd2, '0);
    setDelays(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
    #2;
    checkOutput("reset read_data", read_data, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset handshakes", {in_ready, out_valid}, 0);
    checkOutput("reset out_data", out_data, 0);
    checkOutput("reset last_dir", last_dir, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // LAST with no LAST direction: read completes at once with zero.
    setDelays(0, 0, 0, 0, 0, 0, 0, 0);
    setOp(1'b1, 3'd7, 1'b0, 3'd2, '0);
    runOp("read LAST nil");

    // Fixed LEFT read, LEFT valid 3 cycles late, other neighbours already valid.
    setDelays(0, 0, 3, 0, 0, 0, 0, 0);
    validData[2] = 11'h155;
    setOp(1'b1, 3'd4, 1'b0, 3'd2, '0);
    runOp("read LEFT");

    // Fixed DOWN write of -5 with immediate ready.
    setDelays(0, 0, 0, 0, 0, 0, 0, 0);
    setOp(1'b0, 3'd2, 1'b1, 3'd3, 11'h7FB);
    runOp("write DOWN");

    // ANY read with UP and RIGHT becoming valid together: RIGHT wins.
    setDelays(1, NEVER, NEVER, 1, 0, 0, 0, 0);
    setOp(1'b1, 3'd6, 1'b0, 3'd2, '0);
    runOp("read ANY");

    // ANY write with LEFT and DOWN ready together: LEFT wins; LAST follows it.
    setDelays(0, 0, 0, 0, NEVER, 0, 0, NEVER);
    setOp(1'b0, 3'd2, 1'b1, 3'd6, 11'h0A5);
    runOp("write ANY");
    setDelays(0, 0, 0, 0, 2, 0, 1, 0);
    setOp(1'b0, 3'd2, 1'b1, 3'd7, 11'h3C3);
    runOp("write LAST");

    // MOV UP,RIGHT interrupted by reset while waiting in WR, then replayed.
    setDelays(0, NEVER, NEVER, NEVER, NEVER, NEVER, NEVER, NEVER);
    validData[0] = 11'd42;
    setOp(1'b1, 3'd2, 1'b1, 3'd5, '0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1, 4'b0001, 4'b0000);
    #1;
    checkOutput("mov rd in_ready", in_ready, 4'b0001);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000);
    #1;
    checkOutput("mov wr out_valid", out_valid, 4'b1000);
    checkOutput("mov wr out_data", out_data, 42);
    rst_n = 1'b0;
    #1;
    checkOutput("mov rst read_data", read_data, 0);
    checkOutput("mov rst handshakes", {in_ready, out_valid}, 0);
    checkOutput("mov rst out_data", out_data, 0);
    checkOutput("mov rst done", done, 0);
    checkOutput("mov rst last_dir", last_dir, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
    mLast = 3'd0;
    mReadData = '0;
    setDelays(0, NEVER, NEVER, NEVER, NEVER, NEVER, NEVER, 0);
    validData[0] = 11'd42;
    runOp("mov replay");

    // Random ops with finite neighbour delays.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(1, 3);
      setDelays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      setOp(r[0], 3'($urandom_range(2, 7)), r[1], 3'($urandom_range(2, 7)),
            W'($urandom));
      runOp($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/node_port_io.md
# node_port_io

Blocking port-transfer unit for a TIS-100 execution node, directly downstream of the instruction decoder. It executes every directional read and write (UP, DOWN, LEFT, RIGHT, ANY, LAST) named by the decoded src/dst fields, using valid/ready handshakes to the four neighbour nodes. It stalls the node until each transfer completes and tracks the LAST direction. Decoded sources other than directional ones (NIL, ACC, constant) never reach this block.

## Interface
- WIDTH, 11, data word width (signed, matches decoder constant width)
- clk  in  1  node clock
- rst_n  in  1  asynchronous active-low reset
- read_req  in  1  current op has a directional source; held stable until done
- read_sel  in  3  source target code
- write_req  in  1  current op has a directional destination; held stable until done
- write_sel  in  3  destination target code
- write_data  in  WIDTH  value to send when read_req=0
- read_data  out  WIDTH  registered value captured by the last read
- done  out  1  one-cycle pulse: all requested transfers complete
- stall  out  1  (read_req|write_req) & ~done
- in_valid  in  4  neighbour has data, bit order {RIGHT,LEFT,DOWN,UP}
- in_data  in  4*WIDTH  UP=[10:0], DOWN=[21:11], LEFT=[32:22], RIGHT=[43:33]
- in_ready  out  4  this node accepts from that neighbour
- out_valid  out  4  this node offers data to that neighbour
- out_data  out  WIDTH  shared outgoing word
- out_ready  in  4  neighbour accepts
- last_dir  out  3  current LAST target code, debug

## Operation
- Target codes: NIL=0, ACC=1, UP=2, DOWN=3, LEFT=4, RIGHT=5, ANY=6, LAST=7.
- Transfer on port d occurs in a cycle with valid[d]&ready[d] at the rising edge.
- States: IDLE, RD, WR, DONE.
- IDLE: read_req → RD; else write_req → WR; else stay.
- RD: in_ready asserted on the selected port(s). On transfer, capture in_data of that port into read_data. Then → WR if write_req, else → DONE.
- WR: out_valid asserted on the selected port(s). out_data = read_data if read_req else write_data. On transfer → DONE.
- DONE: done=1; → IDLE.
- ANY read: in_ready on all four ports, masked combinationally so only the highest-priority valid port sees ready. Priority LEFT, RIGHT, UP, DOWN.
- ANY write: out_valid on all four, masked so only the highest-priority ready port sees valid. Priority UP, LEFT, RIGHT, DOWN.
- ANY transfers update last_dir to the port used. Fixed-direction transfers do not change last_dir.
- LAST while last_dir=NIL:
  - a read completes immediately with read_data=0;
  - a write completes immediately and discards the data.
  - "Immediately" means the state advances in the same cycle with no handshake.
- Exactly one transfer per RD or WR visit. No port ever sees both handshake signals outside a transfer.

## Timing
- Reset (async): state=IDLE, read_data=0, last_dir=NIL, done=0, in_ready=0, out_valid=0, out_data=0.
- Requests are sampled in IDLE. Handshake signals are first asserted the following cycle.
- Minimum latency (req to done):
  - read only or write only, with partner ready: 2 cycles;
  - read then write: 3 cycles.
- Blocking is unbounded. While waiting, in_ready/out_valid stay asserted and there is no timeout.
- out_data is stable for the whole WR state.
- Requests changing mid-operation is a protocol violation (undefined behaviour).
- The controller advances the PC on done; IDLE samples the next op in the following cycle.

## Structure
- Add to my_params.vh: TARGET_* codes, DIR_UP/DOWN/LEFT/RIGHT bit indices, PIO_IDLE/RD/WR/DONE state encodings.
- Sub-module port_arbiter: a combinational fixed-priority one-hot pick, plus target-to-mask decode. It is instantiated twice, once with read order and once with write order.
- Top level holds the FSM, read_data register and last_dir register.

## Test plan
- read_sel=LEFT, in_valid[LEFT] asserted 3 cycles late with data 0x155 → read_data=0x155, in_ready only on LEFT, done 1 pulse.
- write_sel=DOWN, write_data=-5, out_ready[DOWN] immediate → out_valid[DOWN] 1 cycle, out_data=0x7FB, done at cycle 2.
- read_sel=ANY with UP and RIGHT valid in the same cycle → RIGHT consumed, UP untouched, last_dir=RIGHT.
- write_sel=ANY with LEFT and DOWN ready in the same cycle → only LEFT sees valid; then write_sel=LAST → targets LEFT.
- After reset, read_sel=LAST → done without handshake, read_data=0.
- MOV UP,RIGHT: read 42 from UP, then rst_n pulsed while in WR → all outputs at reset values immediately; replay completes with out_data=42.
